// File: rtl/gemm_epilogue_unit.sv
// Post-GEMM epilogue engine: streams accumulator rows from SRAM, applies
// bias, saturation, shift and activation, and writes each row back.
module gemm_epilogue_unit #(
   parameter int LANES       = 4,
   parameter int ACC_W       = 32,
   parameter int SRAM_WIDTH  = 256,
   parameter int ADDR_W      = 20,
   parameter int ADDR_STRIDE = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       cfg_src_addr,
   input  logic [ADDR_W-1:0]       cfg_dst_addr,
   input  logic [ADDR_W-1:0]       cfg_bias_addr,
   input  logic [15:0]             cfg_rows,
   input  logic [1:0]              cfg_act,
   input  logic [ACC_W-1:0]        cfg_clip,
   input  logic [4:0]              cfg_shift,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [SRAM_WIDTH-1:0]   mem_wdata,
   input  logic                    mem_ready,
   input  logic [SRAM_WIDTH-1:0]   mem_rdata
);

   localparam int DW = LANES * ACC_W;

   typedef enum logic [2:0] {
      IDLE, BIAS_RD, BIAS_WAIT, ROW_RD, ROW_WAIT, ROW_WR, DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [ADDR_W-1:0]         src_q, dst_q, bias_addr_q;
   logic [15:0]               rows_q, row_q;
   logic [1:0]                act_q;
   logic signed [ACC_W-1:0]   clip_q;
   logic [4:0]                shift_q;
   logic [DW-1:0]             bias_q, result_q, result_d;
   logic                      error_q;
   logic                      last_row;

   assign last_row = (row_q == rows_q - 16'd1);

   // Saturating bias add, arithmetic shift, then activation for one lane.
   function automatic logic [ACC_W-1:0] lane_op(
      input logic signed [ACC_W-1:0] acc,
      input logic signed [ACC_W-1:0] b,
      input logic [4:0]              sh,
      input logic [1:0]              act,
      input logic signed [ACC_W-1:0] clip
   );
      logic signed [ACC_W:0]   sum;
      logic signed [ACC_W-1:0] sat, t;
      sum = $signed({acc[ACC_W-1], acc}) + $signed({b[ACC_W-1], b});
      if (sum[ACC_W] != sum[ACC_W-1])
         sat = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
         sat = sum[ACC_W-1:0];
      t = sat >>> sh;
      case (act)
         2'd1:    lane_op = (t < 0) ? '0 : t;
         2'd2:    lane_op = (t < 0) ? '0 : ((t > clip) ? clip : t);
         default: lane_op = t;
      endcase
   endfunction

   always_comb begin
      // NOTE: every comb output gets a default first so no latch is inferred.
      result_d = '0;
      for (int i = 0; i < LANES; i++)
         result_d[i*ACC_W +: ACC_W] = lane_op(mem_rdata[i*ACC_W +: ACC_W],
                                              bias_q[i*ACC_W +: ACC_W],
                                              shift_q, act_q, clip_q);
   end

   // NOTE: state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (start) state_d = (cfg_rows == 16'd0) ? DONE : BIAS_RD;
         BIAS_RD:   if (mem_ready) state_d = BIAS_WAIT;
         BIAS_WAIT: state_d = ROW_RD;
         ROW_RD:    if (mem_ready) state_d = ROW_WAIT;
         ROW_WAIT:  state_d = ROW_WR;
         ROW_WR:    if (mem_ready) state_d = last_row ? DONE : ROW_RD;
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         src_q       <= '0;
         dst_q       <= '0;
         bias_addr_q <= '0;
         rows_q      <= '0;
         row_q       <= '0;
         act_q       <= '0;
         clip_q      <= '0;
         shift_q     <= '0;
         bias_q      <= '0;
         result_q    <= '0;
         error_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               src_q       <= cfg_src_addr;
               dst_q       <= cfg_dst_addr;
               bias_addr_q <= cfg_bias_addr;
               rows_q      <= cfg_rows;
               row_q       <= '0;
               // Reserved activation runs as pass-through and flags the error.
               act_q       <= (cfg_act == 2'd3) ? 2'd0 : cfg_act;
               error_q     <= (cfg_act == 2'd3);
               clip_q      <= cfg_clip;
               shift_q     <= cfg_shift;
            end
            BIAS_WAIT: bias_q   <= mem_rdata[DW-1:0];
            ROW_WAIT:  result_q <= result_d;
            ROW_WR: if (mem_ready && !last_row) begin
               row_q <= row_q + 16'd1;
               src_q <= src_q + ADDR_W'(ADDR_STRIDE);
               dst_q <= dst_q + ADDR_W'(ADDR_STRIDE);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      error     = error_q;
      mem_req   = (state_q == BIAS_RD) || (state_q == ROW_RD) || (state_q == ROW_WR);
      mem_we    = (state_q == ROW_WR);
      mem_wdata = '0;
      case (state_q)
         BIAS_RD: mem_addr = bias_addr_q;
         ROW_RD:  mem_addr = src_q;
         ROW_WR:  mem_addr = dst_q;
         default: mem_addr = '0;
      endcase
      if (state_q == ROW_WR) mem_wdata[DW-1:0] = result_q;
   end

   generate
      if (SRAM_WIDTH > DW) begin : g_rdata_hi
         logic unused_rdata_hi;
         assign unused_rdata_hi = ^mem_rdata[SRAM_WIDTH-1:DW];
      end
   endgenerate

endmodule
